pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, max MEM_WAIT cycles before timeout error.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_rs1_i / id_rs2_i  input  5 each  ID-stage source register addresses.
REQ-006 SHALL have port id_use_rs1_i / id_use_rs2_i  input  1 each  ID instruction actually reads rs1/rs2.
REQ-007 SHALL have port ex_rd_i  input  5  EX-stage destination register.
REQ-008 SHALL have port ex_memread_i  input  1  EX-stage instruction is a load.
REQ-009 SHALL have port branch_taken_i  input  1  ID-stage branch resolved taken.
REQ-010 SHALL have port dmem_req_i / dmem_ack_i  input  1 each  MEM-stage access pending / data memory completes this cycle.
REQ-011 SHALL have outputs pc_we_o, ifid_we_o, idex_we_o, exmem_we_o  output  1 each  stage-register write enables.
REQ-012 SHALL have outputs ifid_flush_o, idex_flush_o, memwb_bubble_o  output  1 each  insert NOP into IF/ID, ID/EX, MEM/WB.
REQ-013 SHALL have outputs stall_cnt_o  output  CNT_W  and  err_o  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM with states RUN and MEM_WAIT; control outputs Mealy (state + current inputs).
REQ-015 Load-use hazard SHALL be ex_memread_i && ex_rd_i!=0 && ((id_use_rs1_i && id_rs1_i==ex_rd_i) || (id_use_rs2_i && id_rs2_i==ex_rd_i)).
REQ-016 Priority per cycle: memory wait > load-use > branch flush > normal.
REQ-017 RUN, dmem_req_i=1 and dmem_ack_i=0: all four *_we_o=0, memwb_bubble_o=1, other flushes 0; next state MEM_WAIT.
REQ-018 RUN, dmem_req_i&&dmem_ack_i or no req, load-use: pc_we_o=ifid_we_o=0, idex_flush_o=1, idex_we_o=exmem_we_o=1; stay RUN (single bubble).
REQ-019 RUN, no wait, no load-use, branch_taken_i=1: all *_we_o=1, ifid_flush_o=1.
REQ-020 RUN, none of the above: all *_we_o=1, all flush/bubble outputs 0.
REQ-021 MEM_WAIT, dmem_ack_i=0: outputs as REQ-017; wait counter increments.
REQ-022 MEM_WAIT, dmem_ack_i=1: outputs as RUN without the wait condition (REQ-018..020 evaluated); next state RUN; wait counter cleared.
REQ-023 branch_taken_i SHALL be ignored while memory wait or load-use stall active (branch re-evaluated when ID releases).
REQ-024 Wait counter reaching WAIT_LIMIT in MEM_WAIT SHALL set err_o=1 (sticky); FSM keeps waiting for ack.
REQ-025 stall_cnt_o SHALL increment each cycle pc_we_o=0, saturating at all-ones.
REQ-026 ex_rd_i==0 SHALL never cause a stall.

Reset
REQ-027 While rst_i=0: state RUN, wait counter 0, stall_cnt_o=0, err_o=0, all *_we_o=0, all flush/bubble outputs=1.
REQ-028 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately; first cycle after release behaves as RUN.
REQ-029 err_o SHALL clear only via reset.

Structure
REQ-030 Shared package pipe_ctrl_pkg SHALL hold state enum (RUN, MEM_WAIT), REG_ADDR_W=5, default WAIT_LIMIT.
REQ-031 Load-use comparison SHALL be a sub-module load_use_detect (combinational); FSM, counters in top.

Verification
REQ-032 ex_memread=1, ex_rd=5, id_rs1=5, use_rs1=1 -> one cycle pc_we=ifid_we=0, idex_flush=1; next cycle (ex_memread=0) normal; stall_cnt=1.
REQ-033 Same with ex_rd=0 -> no stall, all we=1.
REQ-034 dmem_req=1, ack after 3 cycles -> 3 cycles all we=0, memwb_bubble=1; ack cycle all we=1; stall_cnt=3.
REQ-035 Load-use and branch_taken same cycle -> stall, ifid_flush=0; branch then flushes next cycle.
REQ-036 dmem_req held, no ack 256 cycles -> err_o=1 after cycle 255, stays 1 after ack until reset.
REQ-037 rst_i low during MEM_WAIT -> outputs immediately at reset values; after release, state RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and sizing for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_WAIT_LIMIT = 255;
  typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register a load in EX has not produced yet
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  memread_i,
  output logic                  hazard_o
);
  assign hazard_o = memread_i && rd_i != '0 &&
                    ((use_rs1_i && rs1_i == rd_i) || (use_rs2_i && rs2_i == rd_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for a 5-stage pipeline (memory wait > load-use > branch)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_we_o,
  output logic                  ifid_we_o,
  output logic                  idex_we_o,
  output logic                  exmem_we_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  memwb_bubble_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  err_o
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [WW-1:0]   r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            r_err;
  logic            w_lu;
  logic            w_wait;
  logic            w_pc_we;
  logic            w_ex_we;
  logic            w_ifid_flush;
  logic            w_idex_flush;
  load_use_detect u_lud (
    .rs1_i     (id_rs1_i),
    .rs2_i     (id_rs2_i),
    .use_rs1_i (id_use_rs1_i),
    .use_rs2_i (id_use_rs2_i),
    .rd_i      (ex_rd_i),
    .memread_i (ex_memread_i),
    .hazard_o  (w_lu)
  );
  // Once in MEM_WAIT only the ack matters; the request line is not re-sampled.
  always_comb begin
    w_wait       = (r_state == MEM_WAIT) ? !dmem_ack_i : (dmem_req_i && !dmem_ack_i);
    w_state_nxt  = w_wait ? MEM_WAIT : RUN;
    w_pc_we      = !w_wait && !w_lu;
    w_ex_we      = !w_wait;
    w_idex_flush = !w_wait && w_lu;
    w_ifid_flush = !w_wait && !w_lu && branch_taken_i;
  end
  assign pc_we_o        = rst_i && w_pc_we;
  assign ifid_we_o      = rst_i && w_pc_we;
  assign idex_we_o      = rst_i && w_ex_we;
  assign exmem_we_o     = rst_i && w_ex_we;
  assign ifid_flush_o   = !rst_i || w_ifid_flush;
  assign idex_flush_o   = !rst_i || w_idex_flush;
  assign memwb_bubble_o = !rst_i || w_wait;
  assign stall_cnt_o    = r_stall_cnt;
  assign err_o          = r_err;
  // The wait counter includes the RUN cycle that opens the wait, so it equals the number of stalled cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= !w_wait ? '0 : (r_wait_cnt == WW'(WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + 1'b1);
      r_err       <= r_err || (w_wait && r_wait_cnt == WW'(WAIT_LIMIT - 1));
      r_stall_cnt <= (!w_pc_we && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table plus hand sequences, expected controls queued and checked each cycle
module tb_pipe_hazard_ctrl;
  localparam int LIM = 255;
  localparam logic [6:0] N   = 7'b1111000;
  localparam logic [6:0] BR  = 7'b1111100;
  localparam logic [6:0] LU  = 7'b0011010;
  localparam logic [6:0] W   = 7'b0000001;
  localparam logic [6:0] RST = 7'b0000111;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, req, ack;
  } in_t;
  typedef struct packed {
    in_t        i;
    logic [6:0] e;
  } vec_t;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic id_use_rs1_i, id_use_rs2_i, ex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o, memwb_bubble_o, err_o;
  logic [15:0] stall_cnt_o;
  logic [6:0] ctl;
  int total = 0, bad = 0;
  int m_stall = 0, m_wait = 0;
  logic m_err = 1'b0;
  logic [6:0] q[$];
  vec_t tbl[18];
  assign ctl = {pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o, memwb_bubble_o};
  always #5 clk_i = ~clk_i;
  pipe_hazard_ctrl #(.WAIT_LIMIT(LIM), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
    .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .idex_we_o(idex_we_o), .exmem_we_o(exmem_we_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .memwb_bubble_o(memwb_bubble_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );
  function automatic in_t mk(input logic [4:0] rs1, rs2, input logic u1, u2,
                             input logic [4:0] rd, input logic mr, br, req, ack);
    mk = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr, br: br, req: req, ack: ack};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input in_t v);
    id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_use_rs1_i = v.u1; id_use_rs2_i = v.u2;
    ex_rd_i = v.rd; ex_memread_i = v.mr; branch_taken_i = v.br;
    dmem_req_i = v.req; dmem_ack_i = v.ack;
  endtask
  task automatic model_reset();
    m_stall = 0; m_wait = 0; m_err = 1'b0;
  endtask
  task automatic step(input in_t v, input logic [6:0] e, input string nm);
    logic [6:0] ex;
    drive(v);
    q.push_back(e);
    @(negedge clk_i);
    ex = q.pop_front();
    chk({nm, "_ctl"}, 32'(ctl), 32'(ex));
    chk({nm, "_stall"}, 32'(stall_cnt_o), 32'(m_stall));
    chk({nm, "_err"}, 32'(err_o), 32'(m_err));
    @(posedge clk_i);
    #1;
    if (!ex[6] && m_stall < 65535) m_stall++;
    m_wait = (ex == W) ? m_wait + 1 : 0;
    if (m_wait >= LIM) m_err = 1'b1;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, 32'(ctl), 32'(RST));
    chk({nm, "_stall"}, 32'(stall_cnt_o), 32'd0);
    chk({nm, "_err"}, 32'(err_o), 32'd0);
  endtask
  initial begin
    tbl[0]  = '{mk(1, 2, 1, 1, 3, 1, 0, 0, 0), N};
    tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 0), LU};
    tbl[2]  = '{mk(5, 0, 1, 0, 5, 0, 0, 0, 0), N};
    tbl[3]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0), N};
    tbl[4]  = '{mk(1, 7, 0, 1, 7, 1, 0, 0, 0), LU};
    tbl[5]  = '{mk(1, 7, 0, 0, 7, 1, 0, 0, 0), N};
    tbl[6]  = '{mk(1, 2, 1, 1, 3, 0, 1, 0, 0), BR};
    tbl[7]  = '{mk(9, 2, 1, 1, 9, 1, 1, 0, 0), LU};
    tbl[8]  = '{mk(9, 2, 1, 1, 9, 0, 1, 0, 0), BR};
    tbl[9]  = '{mk(1, 2, 1, 1, 3, 0, 0, 1, 1), N};
    tbl[10] = '{mk(1, 2, 1, 1, 3, 0, 1, 1, 1), BR};
    tbl[11] = '{mk(4, 2, 1, 1, 4, 1, 1, 1, 1), LU};
    tbl[12] = '{mk(1, 2, 1, 1, 3, 0, 0, 1, 0), W};
    tbl[13] = '{mk(4, 2, 1, 1, 4, 1, 1, 1, 0), W};
    tbl[14] = '{mk(1, 2, 1, 1, 3, 0, 0, 0, 0), W};
    tbl[15] = '{mk(1, 2, 1, 1, 3, 0, 1, 0, 1), BR};
    tbl[16] = '{mk(1, 2, 1, 1, 3, 0, 0, 0, 0), N};
    tbl[17] = '{mk(1, 2, 1, 1, 3, 0, 0, 0, 1), N};
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk_reset("por");
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    for (int i = 0; i < 18; i++) step(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));
    // memory wait with ack after three stalled cycles
    for (int i = 0; i < 3; i++) step(mk(1, 2, 1, 1, 3, 0, 0, 1, 0), W, $sformatf("mw%0d", i));
    step(mk(1, 2, 1, 1, 3, 0, 0, 1, 1), N, "mw_ack");
    step(mk(1, 2, 1, 1, 3, 0, 0, 0, 0), N, "mw_post");
    // timeout: error appears after the 255th stalled cycle and survives the ack
    rst_i = 1'b0;
    #1 chk_reset("rst2");
    model_reset();
    #1 rst_i = 1'b1;
    for (int i = 0; i < LIM + 1; i++) step(mk(1, 2, 1, 1, 3, 0, 0, 1, 0), W, $sformatf("to%0d", i));
    step(mk(1, 2, 1, 1, 3, 0, 0, 1, 1), N, "to_ack");
    step(mk(1, 2, 1, 1, 3, 0, 1, 0, 0), BR, "to_sticky");
    // asynchronous reset in the middle of a wait
    step(mk(1, 2, 1, 1, 3, 0, 0, 1, 0), W, "ar_w0");
    step(mk(1, 2, 1, 1, 3, 0, 0, 1, 0), W, "ar_w1");
    #1 rst_i = 1'b0;
    #1 chk_reset("ar_mid");
    model_reset();
    #1 rst_i = 1'b1;
    step(mk(1, 2, 1, 1, 3, 0, 0, 0, 0), N, "ar_run0");
    step(mk(1, 2, 1, 1, 3, 0, 0, 0, 0), N, "ar_run1");
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
